// File: rtl/inert_multi_rd.sv
// -----------------------------------------------------------------------------
// inert_multi_rd
//
// Sequences the iNEMO power-up configuration. On every data-ready interrupt it
// then burst-reads NUM_AXES signed 16-bit channels through the SPI_mnrch
// snd/done handshake. Each complete frame is presented as one coherent word,
// together with a one-cycle valid pulse. The block also counts frames and
// flags a sticky error when the interrupt stays silent for too long.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   INT        in   sensor data-ready (asynchronous, double-flopped here)
//   done       in   SPI_mnrch transaction complete, one-cycle pulse
//   resp[7:0]  in   SPI_mnrch read byte, valid while done=1
//   snd        out  one-cycle start pulse to SPI_mnrch
//   cmd[15:0]  out  command word, stable from snd until the next snd
//   data       out  16*NUM_AXES bits, channel i at data[16i+15:16i]
//   vld        out  one-cycle pulse when data updates
//   init_done  out  high once configuration has completed
//   err_tmo    out  sticky interrupt-timeout flag, cleared by a completed frame
//   frm_cnt    out  completed frame counter, wraps
// -----------------------------------------------------------------------------
module inert_multi_rd #(
    parameter bit          FAST_SIM   = 1'b1,
    parameter int          NUM_AXES   = 3,
    parameter logic [6:0]  BASE_ADDR  = 7'h22,
    parameter logic [47:0] INIT_CMDS  = 48'h0D02_1160_1440,
    parameter int          TMO_CYCLES = 2000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   INT,
    input  logic                   done,
    input  logic [7:0]             resp,
    output logic                   snd,
    output logic [15:0]            cmd,
    output logic [16*NUM_AXES-1:0] data,
    output logic                   vld,
    output logic                   init_done,
    output logic                   err_tmo,
    output logic [15:0]            frm_cnt
);

    localparam int TMR_W  = FAST_SIM ? 9 : 16;
    localparam int NBYTES = 2 * NUM_AXES;
    localparam int BW     = $clog2(NBYTES);
    localparam int TW     = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_B  = BW'(NBYTES - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_PWR, INIT, IDLE, READ} state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr;
    logic [TW-1:0]       tmo_cnt;
    logic                int_q1, int_q2;
    logic [1:0]          k_q, k_d;
    logic [BW-1:0]       b_q, b_d;
    logic [8*NBYTES-1:0] shadow;
    logic                snd_d;
    logic [15:0]         cmd_d;
    logic                cfg_end;
    logic                byte_we;
    logic                frame_end;

    // Configuration words go out MSB word first.
    function automatic logic [15:0] init_word(input logic [1:0] k);
        case (k)
            2'd0:    init_word = INIT_CMDS[47:32];
            2'd1:    init_word = INIT_CMDS[31:16];
            default: init_word = INIT_CMDS[15:0];
        endcase
    endfunction

    // Read command: bit 15 set, register address in [14:8], dummy data byte.
    function automatic logic [15:0] rd_cmd(input logic [BW-1:0] idx);
        rd_cmd = {1'b1, BASE_ADDR + 7'(idx), 8'h00};
    endfunction

    // INT comes from the sensor domain, so it is synchronised through two flops.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_q1 <= 1'b0;
            int_q2 <= 1'b0;
        end else begin
            int_q1 <= INT;
            int_q2 <= int_q1;
        end
    end

    // Free-running power-up timer. Only its all-ones state in WAIT_PWR matters.
    always_ff @(posedge clk) begin
        if (rst) tmr <= '0;
        else     tmr <= tmr + TMR_W'(1);
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        b_d       = b_q;
        snd_d     = 1'b0;
        cmd_d     = cmd;
        cfg_end   = 1'b0;
        byte_we   = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            WAIT_PWR: begin
                if (&tmr) begin
                    snd_d   = 1'b1;
                    cmd_d   = init_word(2'd0);
                    k_d     = 2'd0;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (done) begin
                    if (k_q < 2'd2) begin
                        snd_d = 1'b1;
                        cmd_d = init_word(k_q + 2'd1);
                        k_d   = k_q + 2'd1;
                    end else begin
                        cfg_end = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                if (int_q2) begin
                    snd_d   = 1'b1;
                    cmd_d   = rd_cmd('0);
                    b_d     = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (done) begin
                    byte_we = 1'b1;
                    if (b_q != LAST_B) begin
                        snd_d = 1'b1;
                        cmd_d = rd_cmd(b_q + BW'(1));
                        b_d   = b_q + BW'(1);
                    end else begin
                        frame_end = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = WAIT_PWR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_PWR;
            k_q       <= 2'd0;
            b_q       <= '0;
            snd       <= 1'b0;
            cmd       <= 16'h0000;
            vld       <= 1'b0;
            data      <= '0;
            init_done <= 1'b0;
            frm_cnt   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            b_q       <= b_d;
            snd       <= snd_d;
            cmd       <= cmd_d;
            vld       <= frame_end;
            init_done <= init_done | cfg_end;
            if (frame_end) begin
                // The last byte goes straight from resp, not via the shadow,
                // so the whole frame lands in data on the same edge.
                data    <= {resp, shadow[8*NBYTES-9:0]};
                frm_cnt <= frm_cnt + 16'd1;
            end
        end
    end

    // NOTE: the shadow bytes are not reset. Every byte is rewritten before it
    // can reach data, so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (byte_we) shadow[8*b_q +: 8] <= resp;
    end

    // Timeout counter runs only while IDLE persists. It saturates, and err_tmo
    // stays high until a completed frame clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_tmo <= 1'b0;
        end else begin
            if (state_q != IDLE || state_d != IDLE) tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)            tmo_cnt <= tmo_cnt + TW'(1);

            if (frame_end)                                     err_tmo <= 1'b0;
            else if (state_q == IDLE && tmo_cnt == TMO_MAX)    err_tmo <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inert_multi_rd.sv
// -----------------------------------------------------------------------------
// tb_inert_multi_rd
//
// Directed bench for inert_multi_rd. Instance a is the three-axis block with a
// short timeout. Instance b reads a single axis starting at 0x26. The SPI_mnrch
// side is played by the bench, which answers each snd with a done pulse one
// cycle later. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_inert_multi_rd;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        int_a = 1'b0, int_b = 1'b0;
    logic        done_a = 1'b0, done_b = 1'b0;
    logic [7:0]  resp_a = 8'h00, resp_b = 8'h00;
    logic        snd_a, snd_b, vld_a, vld_b;
    logic        init_a, init_b, tmo_a, tmo_b;
    logic [15:0] cmd_a, cmd_b, frm_a, frm_b;
    logic [47:0] data_a;
    logic [15:0] data_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  resp;
        logic [15:0] exp_cmd;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] init_exp [3];
    logic [47:0] exp_data;

    always #5 clk = ~clk;

    inert_multi_rd #(
        .FAST_SIM(1'b1), .NUM_AXES(3), .BASE_ADDR(7'h22),
        .INIT_CMDS(48'h0D02_1160_1440), .TMO_CYCLES(100)
    ) dut_a (
        .clk(clk), .rst(rst_a), .INT(int_a), .done(done_a), .resp(resp_a),
        .snd(snd_a), .cmd(cmd_a), .data(data_a), .vld(vld_a),
        .init_done(init_a), .err_tmo(tmo_a), .frm_cnt(frm_a)
    );

    inert_multi_rd #(
        .FAST_SIM(1'b1), .NUM_AXES(1), .BASE_ADDR(7'h26)
    ) dut_b (
        .clk(clk), .rst(rst_b), .INT(int_b), .done(done_b), .resp(resp_b),
        .snd(snd_b), .cmd(cmd_b), .data(data_b), .vld(vld_b),
        .init_done(init_b), .err_tmo(tmo_b), .frm_cnt(frm_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_snd(input bit which, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((which ? snd_b : snd_a) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Wait for snd, capture cmd, answer with done+resp one cycle later.
    // Returns on the falling edge just after the DUT has sampled done.
    task automatic serve(input bit which, input logic [7:0] r, output logic [15:0] got);
        bit seen;
        wait_snd(which, 64, seen);
        check(which ? "snd_seen_b" : "snd_seen_a", 64'(seen), 64'd1);
        got = which ? cmd_b : cmd_a;
        @(negedge clk);
        if (which) begin done_b = 1'b1; resp_b = r; end
        else       begin done_a = 1'b1; resp_a = r; end
        @(negedge clk);
        done_a = 1'b0;
        done_b = 1'b0;
    endtask

    task automatic power_up(input bit which);
        int          cyc;
        bit          found;
        logic [15:0] got;
        if (which) rst_b = 1'b0;
        else       rst_a = 1'b0;
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if ((which ? snd_b : snd_a) === 1'b1) found = 1'b1;
        end
        check("powerup_cycles", 64'(cyc), 64'd512);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) check("init_done_early", 64'(which ? init_b : init_a), 64'd0);
            serve(which, 8'h00, got);
            check("init_cmd", 64'(got), 64'(init_exp[k]));
        end
        check("init_done", 64'(which ? init_b : init_a), 64'd1);
    endtask

    task automatic check_reset_a;
        check("rst_snd",  64'(snd_a),  64'd0);
        check("rst_cmd",  64'(cmd_a),  64'd0);
        check("rst_vld",  64'(vld_a),  64'd0);
        check("rst_data", 64'(data_a), 64'd0);
        check("rst_init", 64'(init_a), 64'd0);
        check("rst_tmo",  64'(tmo_a),  64'd0);
        check("rst_frm",  64'(frm_a),  64'd0);
    endtask

    // Full frame on instance a. data must hold its previous value until the
    // vld cycle, then show all channels at once.
    task automatic run_frame(input logic [7:0] rs [6], input logic [47:0] exp_new,
                             input logic [15:0] exp_frm);
        int          lat;
        logic [15:0] got;
        int_a = 1'b1;
        lat   = 0;
        while (snd_a !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("int_to_snd", 64'(lat), 64'd3);
        int_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            serve(1'b0, rs[i], got);
            check("rd_cmd", 64'(got), 64'(vecs[i].exp_cmd));
            if (i < 5) begin
                check("vld_mid",  64'(vld_a),  64'd0);
                check("data_mid", 64'(data_a), 64'(exp_data));
            end else begin
                check("vld_end",  64'(vld_a),  64'd1);
                check("data_end", 64'(data_a), 64'(exp_new));
                check("frm_cnt",  64'(frm_a),  64'(exp_frm));
                check("tmo_clr",  64'(tmo_a),  64'd0);
            end
        end
        exp_data = exp_new;
        @(negedge clk);
        check("vld_pulse", 64'(vld_a), 64'd0);
        check("no_extra",  64'(snd_a), 64'd0);
    endtask

    initial begin
        logic [7:0]  rs_tab [6];
        logic [7:0]  rs_alt [6];
        logic [15:0] got;
        int          n_snd;
        bit          seen;

        vecs[0] = '{8'h11, 16'hA200};
        vecs[1] = '{8'h22, 16'hA300};
        vecs[2] = '{8'h33, 16'hA400};
        vecs[3] = '{8'h44, 16'hA500};
        vecs[4] = '{8'h55, 16'hA600};
        vecs[5] = '{8'h66, 16'hA700};
        init_exp[0] = 16'h0D02;
        init_exp[1] = 16'h1160;
        init_exp[2] = 16'h1440;
        for (int i = 0; i < 6; i++) begin
            rs_tab[i] = vecs[i].resp;
            rs_alt[i] = (i % 2 == 0) ? 8'h34 : 8'h12;
        end
        exp_data = 48'h0;

        // Reset state and power-up configuration
        repeat (3) @(negedge clk);
        check_reset_a();
        power_up(1'b0);

        // Idle with INT low: no traffic, and the timeout eventually fires
        n_snd = 0;
        repeat (120) begin
            @(negedge clk);
            if (snd_a === 1'b1) n_snd++;
        end
        check("idle_no_snd", 64'(n_snd), 64'd0);
        check("tmo_set_idle", 64'(tmo_a), 64'd1);

        // Frame A clears err_tmo; frame B loads 0x1234 per channel; frame C
        // checks coherence against it
        run_frame(rs_tab, 48'h6655_4433_2211, 16'd1);
        run_frame(rs_alt, 48'h1234_1234_1234, 16'd2);
        run_frame(rs_tab, 48'h6655_4433_2211, 16'd3);

        // Timeout after exactly 100 IDLE cycles (one already elapsed)
        repeat (98) @(negedge clk);
        check("tmo_not_yet", 64'(tmo_a), 64'd0);
        @(negedge clk);
        check("tmo_rise", 64'(tmo_a), 64'd1);

        // A stray done in IDLE is ignored
        done_a = 1'b1;
        resp_a = 8'hEE;
        @(negedge clk);
        done_a = 1'b0;
        @(negedge clk);
        check("idle_done_ignored", {62'd0, snd_a, vld_a}, 64'd0);

        // Reset after the third byte of a frame
        int_a = 1'b1;
        wait_snd(1'b0, 20, seen);
        check("rst_frame_start", 64'(seen), 64'd1);
        int_a = 1'b0;
        for (int i = 0; i < 3; i++) serve(1'b0, vecs[i].resp, got);
        rst_a = 1'b1;
        @(negedge clk);
        check_reset_a();
        exp_data = 48'h0;
        power_up(1'b0);

        // frm_cnt wrap
        force dut_a.frm_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_a.frm_cnt;
        run_frame(rs_tab, 48'h6655_4433_2211, 16'h0000);

        // Single-axis instance at 0x26
        power_up(1'b1);
        int_b = 1'b1;
        wait_snd(1'b1, 20, seen);
        check("b_frame_start", 64'(seen), 64'd1);
        int_b = 1'b0;
        serve(1'b1, 8'h5A, got);
        check("b_cmd0", 64'(got), 64'hA600);
        check("b_vld_mid", 64'(vld_b), 64'd0);
        serve(1'b1, 8'hC3, got);
        check("b_cmd1", 64'(got), 64'hA700);
        check("b_vld", 64'(vld_b), 64'd1);
        check("b_data", 64'(data_b), 64'hC35A);
        check("b_frm", 64'(frm_b), 64'd1);
        n_snd = 0;
        repeat (10) begin
            @(negedge clk);
            if (snd_b === 1'b1) n_snd++;
        end
        check("b_two_reads", 64'(n_snd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
